fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding the decode stage's 16-bit instruction input via the IF/ID register.
//  Holds the PC, issues reads to the instruction memory and buffers returned words in a small prefetch queue.
//  Honours decode stall and jump/branch redirects; an empty slot is sent downstream as a NOP bubble (16'h0000).
// PARAMETERS
//  ADDR_W      16     PC / instruction-memory word-address width
//  RESET_PC    0      PC value loaded on reset
//  QUEUE_DEPTH 2      prefetch queue entries (power of 2, >=2)
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  imem_req       out  1       read request, held 1 cycle per request
//  imem_addr      out  ADDR_W  word address of the request (valid while imem_req=1)
//  imem_rdata     in   16      returned instruction word
//  imem_valid     in   1       imem_rdata valid; arrives >=1 cycle after imem_req
//  stall_in       in   1       decode cannot accept; hold IF/ID contents
//  redirect_valid in   1       jump/branch taken; restart fetch at redirect_pc
//  redirect_pc    in   ADDR_W  redirect target
//  instruction    out  16      IF/ID instruction to decode
//  instr_pc       out  ADDR_W  PC of instruction
//  instr_valid    out  1       instruction is real (0 = bubble)
// BEHAVIOUR
//  Reset: pc=RESET_PC, queue empty, FSM=IDLE, imem_req=0, instruction=16'h0000, instr_pc=0, instr_valid=0.
//  Word addressing: pc increments by 1 per accepted request, modulo 2**ADDR_W (wraps all-ones to 0).
//  FSM (at most one outstanding request):
//   IDLE: if free slots (QUEUE_DEPTH - count) >0 and no redirect: assert imem_req, imem_addr=pc, pc<=pc+1, ->WAIT.
//   WAIT: on imem_valid push imem_rdata with its PC into queue, ->IDLE (may re-issue next cycle).
//         on redirect_valid with no imem_valid that cycle: ->DISCARD.
//   DISCARD: drop next imem_valid response, ->IDLE. Must never push it.
//  Redirect (any state): pc<=redirect_pc, queue flushed, IF/ID <= bubble; no request in the redirect cycle;
//   first request to redirect_pc issued the following cycle. Redirect wins over stall_in and over a same-cycle imem_valid.
//  IF/ID update when stall_in=0: pop queue head into IF/ID (instr_valid=1); if queue empty, load bubble (valid=0).
//  stall_in=1: IF/ID holds; queue keeps filling; when full, no new request (IDLE waits).
//  Simultaneous push and pop on a full queue is legal; count unchanged.
//  imem_valid while in IDLE (no outstanding request) is ignored.
//  Reset mid-request: outstanding response after reset deassertion is ignored (FSM is IDLE).
// CONFIGURATION
//  FETCH_BYPASS_EN defined: when queue empty, stall_in=0 and response accepted, imem_rdata goes straight into IF/ID;
//   latency imem_valid@N -> instr_valid@N+1. Queue is not written in that case.
//  Undefined: every word goes through the queue; latency imem_valid@N -> instr_valid@N+2.
// STRUCTURE
//  pipeline_pkg: INSTR_W=16, NOP_INSTR=16'h0000, opcode field [15:11], fetch FSM state encoding (IDLE/WAIT/DISCARD).
//  Sub-module fetch_queue: synchronous FIFO of {pc,instr}, push/pop/flush, full/empty/count; flush dominates push.
// TESTING
//  1 Reset, memory returns word at addr+1 cycle, stall_in=0: addrs 0,1,2.. requested; instruction sequence
//    matches memory, instr_pc 0,1,2; first valid at cycle 3 (2 with FETCH_BYPASS_EN).
//  2 stall_in=1 for 6 cycles after 2 valid words: IF/ID holds; requests stop after queue holds 2;
//    release -> queued words emitted in order, no loss/duplication.
//  3 redirect_valid with redirect_pc=16'h0040 while in WAIT: next instr_valid=0 bubble; late response dropped;
//    next request imem_addr=0x0040; first valid instr_pc=0x0040.
//  4 redirect_valid in same cycle as imem_valid and stall_in=1: response dropped, IF/ID bubble, queue empty.
//  5 RESET_PC=16'hFFFF: requests 0xFFFF then 0x0000 (wrap).
//  6 reset asserted while WAIT with response pending 2 cycles later: all outputs 0 immediately; stray imem_valid ignored;
//    fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline definitions. These include the instruction
//                width, the NOP bubble encoding, the opcode field position
//                and the fetch FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int INSTR_W    = 16;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    // Opcode occupies the top five bits of every instruction word
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 11;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

    // Fetch FSM: at most one instruction-memory request is ever in flight
    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,   // free to issue a request
        FETCH_WAIT    = 2'd1,   // request outstanding, response expected
        FETCH_DISCARD = 2'd2    // request outstanding, response must be dropped
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous prefetch FIFO of {pc, instruction} pairs.
//                Flush dominates push and pop. A push on a full queue is only
//                accepted when a pop happens in the same cycle, and the count
//                then stays the same. The head entry is visible combinationally.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst (async, active-high)
//                i_push/i_push_pc/i_push_instr  - write side
//                i_pop                          - remove head entry
//                i_flush                        - empty the queue
//                o_head_pc/o_head_instr         - oldest entry
//                o_full/o_empty/o_count         - occupancy
// ============================================================================
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ADDR_W-1:0]  i_push_pc,
    input  logic [INSTR_W-1:0] i_push_instr,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic [ADDR_W-1:0]  o_head_pc,
    output logic [INSTR_W-1:0] o_head_instr,
    output logic               o_full,
    output logic               o_empty,
    output logic [CNT_W-1:0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full  = (r_count == C_DEPTH);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // When the queue is full, a write may land in the slot being popped,
    // because the head is read before the clock edge that overwrites it.
    assign w_pop_ok  = i_pop  && !o_empty && !i_flush;
    assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_flush;

    assign o_head_pc    = r_pc_mem[r_rd_ptr];
    assign o_head_instr = r_instr_mem[r_rd_ptr];

    // Storage needs no reset; the pointers and count determine validity
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_pc_mem[r_wr_ptr]    <= i_push_pc;
            r_instr_mem[r_wr_ptr] <= i_push_instr;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. It holds the PC and issues one
//                word read at a time to the instruction memory. Returned
//                words are buffered in a prefetch queue, and the IF/ID
//                register that feeds decode is driven from that queue. An
//                empty slot is sent downstream as a NOP bubble (valid=0).
//                Redirects flush the queue and restart fetch at the new PC.
//  Revision    : 1.0 - initial release
//  Config      : FETCH_BYPASS_EN - when the queue is empty and decode is not
//                stalled, an accepted response is written straight into
//                IF/ID, which saves one cycle of latency.
//  Ports       : clk, reset (async, active-high)
//                imem_req/imem_addr            - memory request (1 cycle each)
//                imem_rdata/imem_valid         - memory response
//                stall_in                      - decode hold
//                redirect_valid/redirect_pc    - jump/branch restart
//                instruction/instr_pc/instr_valid - IF/ID register
// ============================================================================
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] C_QUEUE_DEPTH = CNT_W'(QUEUE_DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_pc;      // PC of the request in flight
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;
    logic               r_instr_valid;

    logic               w_issue;
    logic               w_accept;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_free_slots;

    logic [ADDR_W-1:0]  w_q_head_pc;
    logic [INSTR_W-1:0] w_q_head_instr;
    logic               w_q_full;
    logic               w_q_empty;
    logic [CNT_W-1:0]   w_q_count;

    // ------------------------------------------------------------------
    // Prefetch queue
    // ------------------------------------------------------------------
    fetch_queue #(
        .DEPTH  (QUEUE_DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk          (clk),
        .rst          (reset),
        .i_push       (w_push),
        .i_push_pc    (r_req_pc),
        .i_push_instr (imem_rdata),
        .i_pop        (w_pop),
        .i_flush      (redirect_valid),
        .o_head_pc    (w_q_head_pc),
        .o_head_instr (w_q_head_instr),
        .o_full       (w_q_full),
        .o_empty      (w_q_empty),
        .o_count      (w_q_count)
    );

    // A request is issued only if a queue slot is guaranteed for its
    // response. Slots freed by a same-cycle pop are not counted.
    assign w_free_slots = C_QUEUE_DEPTH - w_q_count;

    // ------------------------------------------------------------------
    // Fetch FSM: next state and request strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            FETCH_IDLE: begin
                if (!redirect_valid && (w_free_slots != '0)) begin
                    w_issue      = 1'b1;
                    w_next_state = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_valid) begin
                    // A redirect in the same cycle makes this word stale
                    w_accept     = !redirect_valid;
                    w_next_state = FETCH_IDLE;
                end else if (redirect_valid) begin
                    w_next_state = FETCH_DISCARD;
                end
            end
            FETCH_DISCARD: begin
                if (imem_valid) begin
                    w_next_state = FETCH_IDLE;
                end
            end
            default: begin
                w_next_state = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef FETCH_BYPASS_EN
    // Skip the queue only when nothing is ahead of this word and decode
    // will take it this cycle; otherwise ordering would break.
    assign w_bypass = w_accept && w_q_empty && !stall_in;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_pop  = !stall_in && !redirect_valid && !w_q_empty;
    assign w_push = w_accept && !w_bypass && (!w_q_full || w_pop);

    // The request is gated by reset so that the outputs go quiet as soon
    // as reset is asserted.
    assign imem_req  = w_issue && !reset;
    assign imem_addr = r_pc;

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_issue) begin
            r_pc     <= r_pc + ADDR_W'(1);
            r_req_pc <= r_pc;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect overrides stall: whatever decode holds is wrong-path
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
        end else if (!stall_in) begin
            if (!w_q_empty) begin
                r_instr       <= w_q_head_instr;
                r_instr_pc    <= w_q_head_pc;
                r_instr_valid <= 1'b1;
            end else if (w_bypass) begin
                r_instr       <= imem_rdata;
                r_instr_pc    <= r_req_pc;
                r_instr_valid <= 1'b1;
            end else begin
                r_instr       <= NOP_INSTR;
                r_instr_pc    <= '0;
                r_instr_valid <= 1'b0;
            end
        end
    end

    assign instruction = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

endmodule : fetch_stage
`default_nettype wire
